corner_quad_renderer: RTL and testbench

Reverse-direction companion to the frame corner detector. It accepts the four per-frame corner addresses (UL/UR/DL/DR, {row,col}) plus a success flag, and latches them at frame boundaries. It then rasterises the enclosed quadrilateral back into a 1-bit pixel stream, in raster order and paced by the pixel-valid strobe. The output drives the VGA overlay/mask path, e.g. for region highlighting and crop masking.

---
 rtl/corner_pkg.sv | 42 ++++
 rtl/corner_quad_renderer_edge_eval.sv | 43 ++++
 rtl/corner_quad_renderer.sv | 134 +++++++++++++
 tb/tb_corner_quad_renderer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/corner_pkg.sv
// Shared types for the corner renderer: pixel address, corner bundle, full-frame default set.
// Optional CORNER_MARKER_EN feature lives in the top; this package is feature-independent.
package corner_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
    } pix_addr_t;

    typedef struct packed {
        pix_addr_t ul;
        pix_addr_t ur;
        pix_addr_t dl;
        pix_addr_t dr;
        logic      success;
    } corner_set_t;

    function automatic corner_set_t full_frame_set(input int h, input int v);
        corner_set_t s;
        s.ul.row = 10'd0;
        s.ul.col = 10'd0;
        s.ur.row = 10'd0;
        s.ur.col = 10'(h - 1);
        s.dl.row = 10'(v - 1);
        s.dl.col = 10'd0;
        s.dr.row = 10'(v - 1);
        s.dr.col = 10'(h - 1);
        s.success = 1'b0;
        return s;
    endfunction

    localparam corner_set_t FULL_FRAME_SET = full_frame_set(H_ACTIVE_DEF, V_ACTIVE_DEF);

    // Unsigned 10-bit coordinates widened to a signed 11-bit difference.
    function automatic logic signed [10:0] addr_diff(input logic [9:0] x, input logic [9:0] y);
        return $signed({1'b0, x}) - $signed({1'b0, y});
    endfunction

endpackage

// File: rtl/corner_quad_renderer_edge_eval.sv
// Half-plane test for one quad edge a->b: E = (col-ca)*(rb-ra) - (row-ra)*(cb-ca).
// Latency 2 cycles (differences, then products/compare); free-running, no backpressure.
module edge_eval
    import corner_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  pix_addr_t i_pos,
    input  pix_addr_t i_a,
    input  pix_addr_t i_b,
    output logic      o_inside_n
);

    logic signed [10:0] r_dcol;
    logic signed [10:0] r_drow;
    logic signed [10:0] r_ab_row;
    logic signed [10:0] r_ab_col;
    logic signed [21:0] w_p0;
    logic signed [21:0] w_p1;
    logic signed [22:0] w_e;

    assign w_p0 = r_dcol * r_ab_row;
    assign w_p1 = r_drow * r_ab_col;
    assign w_e  = $signed({w_p0[21], w_p0}) - $signed({w_p1[21], w_p1});

    // o_inside_n is high when E <= 0, i.e. the pixel is on or inside this edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dcol     <= '0;
            r_drow     <= '0;
            r_ab_row   <= '0;
            r_ab_col   <= '0;
            o_inside_n <= 1'b0;
        end else begin
            r_dcol     <= addr_diff(i_pos.col, i_a.col);
            r_drow     <= addr_diff(i_pos.row, i_a.row);
            r_ab_row   <= addr_diff(i_b.row, i_a.row);
            r_ab_col   <= addr_diff(i_b.col, i_a.col);
            o_inside_n <= w_e[22] || (w_e == 23'sd0);
        end
    end

endmodule

// File: rtl/corner_quad_renderer.sv
// Rasterises the latched corner quad into a 1-bit mask stream; optional CORNER_MARKER_EN adds corner boxes.
// Latency 2 cycles from i_valid to o_valid; no stalls, bubbles pass straight through.
module corner_quad_renderer
    import corner_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter logic FAIL_FILL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_corners_valid,
    input  logic        i_success,
    input  logic [19:0] i_ul_addr,
    input  logic [19:0] i_ur_addr,
    input  logic [19:0] i_dl_addr,
    input  logic [19:0] i_dr_addr,
    input  logic        i_valid,
    output logic        o_valid,
    output logic        o_data,
    output logic [9:0]  o_row,
    output logic [9:0]  o_col,
    output logic        o_frame_start,
    output logic        o_marker
);

    localparam corner_set_t RST_SET = full_frame_set(H_ACTIVE, V_ACTIVE);
    localparam logic [9:0]  H_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);

    logic [9:0]  r_row, r_col;
    corner_set_t r_shadow, r_active;
    corner_set_t w_in_set, w_set;
    pix_addr_t   w_pos;
    logic        w_accept0;
    logic [3:0]  w_inside;

    logic        r_vld1, r_fs1, r_succ1;
    logic [9:0]  r_row1, r_col1;
    logic        r_vld2, r_fs2, r_succ2;
    logic [9:0]  r_row2, r_col2;

    assign w_in_set  = {i_ul_addr, i_ur_addr, i_dl_addr, i_dr_addr, i_success};
    assign w_pos     = {r_row, r_col};
    assign w_accept0 = i_valid && (r_row == 10'd0) && (r_col == 10'd0);
    // The pixel at (0,0) must already see the set it loads, including a same-cycle bundle.
    assign w_set     = w_accept0 ? (i_corners_valid ? w_in_set : r_shadow) : r_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row    <= '0;
            r_col    <= '0;
            r_shadow <= RST_SET;
            r_active <= RST_SET;
            r_vld1   <= 1'b0;
            r_fs1    <= 1'b0;
            r_succ1  <= 1'b0;
            r_row1   <= '0;
            r_col1   <= '0;
            r_vld2   <= 1'b0;
            r_fs2    <= 1'b0;
            r_succ2  <= 1'b0;
            r_row2   <= '0;
            r_col2   <= '0;
        end else begin
            if (i_corners_valid) r_shadow <= w_in_set;
            if (w_accept0)       r_active <= w_set;
            if (i_valid) begin
                if (r_col == H_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == V_LAST) ? 10'd0 : r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
            r_vld1  <= i_valid;
            r_fs1   <= w_accept0;
            r_succ1 <= w_set.success;
            r_row1  <= r_row;
            r_col1  <= r_col;
            r_vld2  <= r_vld1;
            r_fs2   <= r_fs1;
            r_succ2 <= r_succ1;
            r_row2  <= r_row1;
            r_col2  <= r_col1;
        end
    end

    edge_eval u_edge_top   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_pos(w_pos),
                            .i_a(w_set.ul), .i_b(w_set.ur), .o_inside_n(w_inside[0]));
    edge_eval u_edge_right (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_pos(w_pos),
                            .i_a(w_set.ur), .i_b(w_set.dr), .o_inside_n(w_inside[1]));
    edge_eval u_edge_bot   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_pos(w_pos),
                            .i_a(w_set.dr), .i_b(w_set.dl), .o_inside_n(w_inside[2]));
    edge_eval u_edge_left  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_pos(w_pos),
                            .i_a(w_set.dl), .i_b(w_set.ul), .o_inside_n(w_inside[3]));

    assign o_valid       = r_vld2;
    assign o_frame_start = r_fs2;
    assign o_row         = r_row2;
    assign o_col         = r_col2;
    // Gated by valid so bubbles and reset always read as 0, whatever FAIL_FILL is.
    assign o_data        = r_vld2 && (r_succ2 ? (&w_inside) : FAIL_FILL);

`ifdef CORNER_MARKER_EN
    logic r_mark1, r_mark2;
    logic w_near;

    function automatic logic near_corner(input pix_addr_t p, input pix_addr_t c);
        logic signed [10:0] dr, dc;
        dr = addr_diff(p.row, c.row);
        dc = addr_diff(p.col, c.col);
        return (dr >= -11'sd2) && (dr <= 11'sd2) && (dc >= -11'sd2) && (dc <= 11'sd2);
    endfunction

    assign w_near = near_corner(w_pos, w_set.ul) || near_corner(w_pos, w_set.ur) ||
                    near_corner(w_pos, w_set.dl) || near_corner(w_pos, w_set.dr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mark1 <= 1'b0;
            r_mark2 <= 1'b0;
        end else begin
            r_mark1 <= w_near;
            r_mark2 <= r_mark1 && r_vld1;
        end
    end

    assign o_marker = r_mark2;
`else
    assign o_marker = 1'b0;
`endif

endmodule

// File: tb/tb_corner_quad_renderer.sv
// Directed bench for corner_quad_renderer on a reduced 64x48 raster; marker checks under CORNER_MARKER_EN.
module tb_corner_quad_renderer;
    import corner_pkg::*;

    localparam int H = 64;
    localparam int V = 48;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_corners_valid = 1'b0;
    logic        i_success = 1'b0;
    logic [19:0] i_ul_addr = '0, i_ur_addr = '0, i_dl_addr = '0, i_dr_addr = '0;
    logic        i_valid = 1'b0;
    logic        o_valid, o_data, o_frame_start, o_marker;
    logic [9:0]  o_row, o_col;

    corner_quad_renderer #(.H_ACTIVE(H), .V_ACTIVE(V), .FAIL_FILL(1'b0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_corners_valid(i_corners_valid),
        .i_success(i_success), .i_ul_addr(i_ul_addr), .i_ur_addr(i_ur_addr),
        .i_dl_addr(i_dl_addr), .i_dr_addr(i_dr_addr), .i_valid(i_valid),
        .o_valid(o_valid), .o_data(o_data), .o_row(o_row), .o_col(o_col),
        .o_frame_start(o_frame_start), .o_marker(o_marker));

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    int   n_vec = 0, n_err = 0;
    logic prev_v = 1'b0;
    int   exp_r = 0, exp_c = 0;
    int   seq_err, dly_err, ones, rect_ones, fs_cnt, fs_bad, vcnt, mcnt;
    logic map_d [V][H];
    logic map_m [V][H];

    function automatic logic [19:0] A(input int r, input int c);
        return {10'(r), 10'(c)};
    endfunction

    task automatic clr_stats();
        seq_err = 0; dly_err = 0; ones = 0; rect_ones = 0;
        fs_cnt = 0; fs_bad = 0; vcnt = 0; mcnt = 0;
    endtask

    // One clock; observes the outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (o_valid !== prev_v) dly_err++;
        prev_v = i_valid;
        if (o_frame_start && !(o_valid && o_row == 0 && o_col == 0)) fs_bad++;
        if (o_valid === 1'b1) begin
            vcnt++;
            if (o_row != 10'(exp_r) || o_col != 10'(exp_c)) seq_err++;
            if (exp_c == H - 1) begin
                exp_c = 0;
                exp_r = (exp_r == V - 1) ? 0 : exp_r + 1;
            end else exp_c++;
            if (o_row < V && o_col < H) begin
                map_d[o_row][o_col] = o_data;
                map_m[o_row][o_col] = o_marker;
            end
            if (o_data) begin
                ones++;
                if (o_row >= 10 && o_row <= 39 && o_col >= 20 && o_col <= 49) rect_ones++;
            end
            if (o_marker) mcnt++;
            if (o_frame_start) fs_cnt++;
        end
    endtask

    task automatic stream_frame(input bit pulse, input int pr, input int pc,
                                input logic [19:0] ul, input logic [19:0] ur,
                                input logic [19:0] dl, input logic [19:0] dr, input logic s);
        clr_stats();
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                i_valid = 1'b1;
                i_corners_valid = pulse && r == pr && c == pc;
                i_ul_addr = ul; i_ur_addr = ur; i_dl_addr = dl; i_dr_addr = dr;
                i_success = s;
                tick();
            end
        end
        i_valid = 1'b0;
        i_corners_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick(); tick();
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_valid); end
        n_vec++; if (o_data !== 1'b0) begin n_err++; $display("FAIL rst_data: got %b want 0", o_data); end
        n_vec++; if (o_row !== 10'd0) begin n_err++; $display("FAIL rst_row: got %0d want 0", o_row); end
        n_vec++; if (o_col !== 10'd0) begin n_err++; $display("FAIL rst_col: got %0d want 0", o_col); end
        n_vec++; if (o_frame_start !== 1'b0) begin n_err++; $display("FAIL rst_fs: got %b want 0", o_frame_start); end
        n_vec++; if (o_marker !== 1'b0) begin n_err++; $display("FAIL rst_marker: got %b want 0", o_marker); end
        i_rst_n = 1'b1;
        exp_r = 0; exp_c = 0; prev_v = 1'b0;
        stream_frame(1'b0, 0, 0, '0, '0, '0, '0, 1'b0);
        n_vec++; if (vcnt != H * V) begin n_err++; $display("FAIL rst_frame_pixels: got %0d want %0d", vcnt, H * V); end
        n_vec++; if (ones != 0) begin n_err++; $display("FAIL rst_frame_ones: got %0d want 0", ones); end
        n_vec++; if (fs_cnt != 1) begin n_err++; $display("FAIL rst_frame_fs_count: got %0d want 1", fs_cnt); end
        n_vec++; if (fs_bad != 0) begin n_err++; $display("FAIL rst_frame_fs_align: got %0d want 0", fs_bad); end
        n_vec++; if (seq_err != 0) begin n_err++; $display("FAIL rst_frame_seq: got %0d want 0", seq_err); end
        n_vec++; if (dly_err != 0) begin n_err++; $display("FAIL rst_frame_delay: got %0d want 0", dly_err); end
    endtask

    task automatic test_rect();
        // Mid-frame pulse: this frame keeps the reset set, the next one shows the rectangle.
        stream_frame(1'b1, 5, 5, A(10, 20), A(10, 49), A(39, 20), A(39, 49), 1'b1);
        n_vec++; if (ones != 0) begin n_err++; $display("FAIL rect_cur_frame_ones: got %0d want 0", ones); end
        stream_frame(1'b0, 0, 0, '0, '0, '0, '0, 1'b0);
        n_vec++; if (ones != 900) begin n_err++; $display("FAIL rect_ones: got %0d want 900", ones); end
        n_vec++; if (rect_ones != 900) begin n_err++; $display("FAIL rect_inside_ones: got %0d want 900", rect_ones); end
        n_vec++; if (fs_cnt != 1) begin n_err++; $display("FAIL rect_fs_count: got %0d want 1", fs_cnt); end
`ifdef CORNER_MARKER_EN
        n_vec++; if (mcnt != 100) begin n_err++; $display("FAIL mark_count: got %0d want 100", mcnt); end
        n_vec++; if (map_m[7][20] !== 1'b0) begin n_err++; $display("FAIL mark_7_20: got %b want 0", map_m[7][20]); end
        n_vec++; if (map_m[8][18] !== 1'b1) begin n_err++; $display("FAIL mark_8_18: got %b want 1", map_m[8][18]); end
        n_vec++; if (map_m[12][22] !== 1'b1) begin n_err++; $display("FAIL mark_12_22: got %b want 1", map_m[12][22]); end
        n_vec++; if (map_m[41][51] !== 1'b1) begin n_err++; $display("FAIL mark_41_51: got %b want 1", map_m[41][51]); end
        n_vec++; if (map_m[38][46] !== 1'b0) begin n_err++; $display("FAIL mark_38_46: got %b want 0", map_m[38][46]); end
`else
        n_vec++; if (mcnt != 0) begin n_err++; $display("FAIL mark_off_count: got %0d want 0", mcnt); end
`endif
    endtask

    task automatic test_diamond();
        // Bundle arrives with the (0,0) accept, so this very frame uses it.
        stream_frame(1'b1, 0, 0, A(0, 32), A(24, 63), A(24, 0), A(47, 32), 1'b1);
        n_vec++; if (map_d[24][32] !== 1'b1) begin n_err++; $display("FAIL dia_24_32: got %b want 1", map_d[24][32]); end
        n_vec++; if (map_d[0][32] !== 1'b1) begin n_err++; $display("FAIL dia_0_32: got %b want 1", map_d[0][32]); end
        n_vec++; if (map_d[0][0] !== 1'b0) begin n_err++; $display("FAIL dia_0_0: got %b want 0", map_d[0][0]); end
        n_vec++; if (map_d[12][16] !== 1'b1) begin n_err++; $display("FAIL dia_12_16: got %b want 1", map_d[12][16]); end
        n_vec++; if (map_d[11][15] !== 1'b0) begin n_err++; $display("FAIL dia_11_15: got %b want 0", map_d[11][15]); end
        n_vec++; if (map_d[47][32] !== 1'b1) begin n_err++; $display("FAIL dia_47_32: got %b want 1", map_d[47][32]); end
        n_vec++; if (map_d[47][33] !== 1'b0) begin n_err++; $display("FAIL dia_47_33: got %b want 0", map_d[47][33]); end
    endtask

    task automatic test_midframe();
        stream_frame(1'b1, 10, 10, A(10, 20), A(10, 49), A(39, 20), A(39, 49), 1'b1);
        n_vec++; if (map_d[47][32] !== 1'b1) begin n_err++; $display("FAIL mid_keep_47_32: got %b want 1", map_d[47][32]); end
        n_vec++; if (map_d[24][32] !== 1'b1) begin n_err++; $display("FAIL mid_keep_24_32: got %b want 1", map_d[24][32]); end
        stream_frame(1'b0, 0, 0, '0, '0, '0, '0, 1'b0);
        n_vec++; if (ones != 900) begin n_err++; $display("FAIL mid_next_ones: got %0d want 900", ones); end
        n_vec++; if (map_d[47][32] !== 1'b0) begin n_err++; $display("FAIL mid_next_47_32: got %b want 0", map_d[47][32]); end
    endtask

    task automatic test_fail_fill();
        stream_frame(1'b1, 0, 0, A(10, 20), A(10, 49), A(39, 20), A(39, 49), 1'b0);
        n_vec++; if (ones != 0) begin n_err++; $display("FAIL fill_ones: got %0d want 0", ones); end
    endtask

    task automatic test_gaps();
        int acc;
        logic v;
        i_valid = 1'b0;
        i_corners_valid = 1'b1;
        i_ul_addr = A(10, 20); i_ur_addr = A(10, 49); i_dl_addr = A(39, 20); i_dr_addr = A(39, 49);
        i_success = 1'b1;
        tick();
        i_corners_valid = 1'b0;
        clr_stats();
        acc = 0;
        while (acc < H * V + 25 * H) begin
            v = 1'($urandom_range(0, 1));
            i_valid = v;
            // Pending full-frame success set, due to be dropped by the reset below.
            i_corners_valid = v && acc == H * V + 5 * H;
            i_ul_addr = A(0, 0); i_ur_addr = A(0, H - 1); i_dl_addr = A(V - 1, 0); i_dr_addr = A(V - 1, H - 1);
            tick();
            if (v) acc++;
        end
        i_valid = 1'b0;
        i_corners_valid = 1'b0;
        tick(); tick();
        n_vec++; if (dly_err != 0) begin n_err++; $display("FAIL gap_delay: got %0d want 0", dly_err); end
        n_vec++; if (seq_err != 0) begin n_err++; $display("FAIL gap_seq: got %0d want 0", seq_err); end
        n_vec++; if (ones != 1350) begin n_err++; $display("FAIL gap_ones: got %0d want 1350", ones); end
        i_valid = 1'b1;
        tick();
        i_rst_n = 1'b0;
        #1;
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
        n_vec++; if (o_row !== 10'd0 || o_col !== 10'd0) begin n_err++; $display("FAIL midrst_pos: got %0d,%0d want 0,0", o_row, o_col); end
        i_valid = 1'b0;
        tick();
        i_rst_n = 1'b1;
        exp_r = 0; exp_c = 0; prev_v = 1'b0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid: got %b want 1", o_valid); end
        n_vec++; if (o_row !== 10'd0 || o_col !== 10'd0) begin n_err++; $display("FAIL post_rst_pos: got %0d,%0d want 0,0", o_row, o_col); end
        n_vec++; if (o_frame_start !== 1'b1) begin n_err++; $display("FAIL post_rst_fs: got %b want 1", o_frame_start); end
        n_vec++; if (o_data !== 1'b0) begin n_err++; $display("FAIL post_rst_shadow_lost: got %b want 0", o_data); end
        tick();
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_bubble: got %b want 0", o_valid); end
    endtask

    initial begin
        test_reset();
        test_rect();
        test_diamond();
        test_midframe();
        test_fail_fill();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
